// File: rtl/iter_muldiv_unit.sv
// Radix-2 iterative mul/div (WIDTH x WIDTH -> 2*WIDTH, 2*WIDTH / WIDTH), ZNCO flags; done at E0+W+2 (precheck E0+3).
// Caller stalls on busy; start is ignored while busy. `define MULDIV_EARLY_OUT_EN ends MUL* once the multiplier is exhausted.
module iter_muldiv_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_a_hi,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic [3:0]       flags
);

  localparam int W  = WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [W-1:0] HALF = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_RUN, S_FIX, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [1:0]     op_q, op_d;
  logic [W-1:0]   a_lo_q, a_lo_d, a_hi_q, a_hi_d, b_q, b_d;
  logic [2*W-1:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           neg_q, neg_d, rem_neg_q, rem_neg_d;
  logic           pre_dz_q, pre_dz_d, pre_ov_q, pre_ov_d, hold_q, hold_d;
  logic [W-1:0]   res_lo_q, res_lo_d, res_hi_q, res_hi_d;
  logic [3:0]     flags_q, flags_d;

  logic           is_signed, is_div, a_neg, b_neg;
  logic [W-1:0]   a_mag, b_mag;
  logic [2*W-1:0] dvd, dvd_mag, mul_sum, prod;
  logic [W:0]     div_top;
  logic           div_ge;
  logic [W-1:0]   div_rem, q_mag, r_mag, q_val, r_val, div_lo;
  logic           q_ovf, mul_stop, mul_ext;

  assign is_signed = op_q[0];
  assign is_div    = op_q[1];
  assign a_neg     = is_signed & (is_div ? a_hi_q[W-1] : a_lo_q[W-1]);
  assign b_neg     = is_signed & b_q[W-1];
  assign a_mag     = a_neg ? -a_lo_q : a_lo_q;
  assign b_mag     = b_neg ? -b_q : b_q;
  assign dvd       = {a_hi_q, a_lo_q};
  assign dvd_mag   = a_neg ? -dvd : dvd;

  // Partial remainder stays below the divisor, so the W-bit difference is exact.
  assign div_top   = acc_q[2*W-1:W-1];
  assign div_ge    = div_top >= {1'b0, mcand_q[W-1:0]};
  assign div_rem   = div_top[W-1:0] - mcand_q[W-1:0];

  assign mul_sum   = mplier_q[0] ? acc_q + mcand_q : acc_q;
  assign prod      = neg_q ? -acc_q : acc_q;
  assign mul_ext   = is_signed ? (prod[2*W-1:W] != {W{prod[W-1]}}) : (prod[2*W-1:W] != '0);

  assign q_mag     = acc_q[W-1:0];
  assign r_mag     = acc_q[2*W-1:W];
  assign q_val     = neg_q ? -q_mag : q_mag;
  assign r_val     = rem_neg_q ? -r_mag : r_mag;
  assign q_ovf     = is_signed & (neg_q ? (q_mag > HALF) : q_mag[W-1]);
  assign div_lo    = q_ovf ? '1 : q_val;

`ifdef MULDIV_EARLY_OUT_EN
  assign mul_stop  = (cnt_q == CW'(1)) || (mplier_q[W-1:1] == '0);
`else
  assign mul_stop  = (cnt_q == CW'(1));
`endif

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_lo_d    = a_lo_q;
    a_hi_d    = a_hi_q;
    b_d       = b_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    pre_dz_d  = pre_dz_q;
    pre_ov_d  = pre_ov_q;
    hold_d    = hold_q;
    res_lo_d  = res_lo_q;
    res_hi_d  = res_hi_q;
    flags_d   = flags_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          a_lo_d  = src_a;
          a_hi_d  = src_a_hi;
          b_d     = src_b;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        neg_d     = a_neg ^ b_neg;
        rem_neg_d = a_neg;
        cnt_d     = CW'(W);
        pre_dz_d  = 1'b0;
        pre_ov_d  = 1'b0;
        hold_d    = 1'b0;
        state_d   = S_RUN;
        if (is_div) begin
          acc_d   = dvd_mag;
          mcand_d = {{W{1'b0}}, b_mag};
          // Prechecked results wait one extra FIX cycle before DONE.
          if (b_q == '0) begin
            pre_dz_d = 1'b1;
            hold_d   = 1'b1;
            state_d  = S_FIX;
          end else if (dvd_mag[2*W-1:W] >= b_mag) begin
            pre_ov_d = 1'b1;
            hold_d   = 1'b1;
            state_d  = S_FIX;
          end
        end else begin
          acc_d    = '0;
          mcand_d  = {{W{1'b0}}, a_mag};
          mplier_d = b_mag;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (is_div) begin
          acc_d = {div_ge ? div_rem : div_top[W-1:0], acc_q[W-2:0], div_ge};
          if (cnt_q == CW'(1)) state_d = S_FIX;
        end else begin
          acc_d    = mul_sum;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          if (mul_stop) state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (hold_q) begin
          hold_d = 1'b0;
        end else begin
          state_d = S_DONE;
          if (!is_div) begin
            res_lo_d = prod[W-1:0];
            res_hi_d = prod[2*W-1:W];
            flags_d  = {prod == '0, prod[2*W-1], mul_ext, mul_ext};
          end else if (pre_dz_q) begin
            res_lo_d = '1;
            res_hi_d = a_lo_q;
            flags_d  = 4'b0110;
          end else if (pre_ov_q) begin
            res_lo_d = '1;
            res_hi_d = a_hi_q;
            flags_d  = 4'b0101;
          end else begin
            res_lo_d = div_lo;
            res_hi_d = r_val;
            flags_d  = {div_lo == '0, div_lo[W-1], 1'b0, q_ovf};
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      a_lo_q    <= '0;
      a_hi_q    <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      pre_dz_q  <= 1'b0;
      pre_ov_q  <= 1'b0;
      hold_q    <= 1'b0;
      res_lo_q  <= '0;
      res_hi_q  <= '0;
      flags_q   <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_lo_q    <= a_lo_d;
      a_hi_q    <= a_hi_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      pre_dz_q  <= pre_dz_d;
      pre_ov_q  <= pre_ov_d;
      hold_q    <= hold_d;
      res_lo_q  <= res_lo_d;
      res_hi_q  <= res_hi_d;
      flags_q   <= flags_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign res_lo = res_lo_q;
  assign res_hi = res_hi_q;
  assign flags  = flags_q;

endmodule
